// File: rtl/pc_next_unit.sv
// Program-counter register and next-PC selector. Holds the PC under stall and
// keeps the highest-priority redirect seen during a stall until the stall ends.
module pc_next_unit #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000,
    parameter logic [31:0] EXC_VEC  = 32'h0040_0004
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [31:0] br_off,
    input  logic        jump,
    input  logic [25:0] instr_index,
    input  logic        jr,
    input  logic [31:0] jr_target,
    input  logic        exc,
    input  logic        eret,
    input  logic [31:0] epc,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        redirect,
    output logic        addr_err
);

    // Larger value means higher priority; SEQ means no request.
    typedef enum logic [2:0] {
        PRIO_SEQ  = 3'd0,
        PRIO_BR   = 3'd1,
        PRIO_JUMP = 3'd2,
        PRIO_JR   = 3'd3,
        PRIO_ERET = 3'd4,
        PRIO_EXC  = 3'd5
    } prio_e;

    logic [31:0] pc_r;
    logic        redirect_r;
    logic        addr_err_r;
    logic        pend_valid_r;
    logic [31:0] pend_tgt_r;
    prio_e       pend_prio_r;

    logic [31:0] pc_plus4_s;
    prio_e       sel_prio_s;
    logic [31:0] sel_tgt_s;
    logic        misaligned_s;
    logic [31:0] chk_tgt_s;

    logic [31:0] pc_nxt_s;
    logic        redirect_nxt_s;
    logic        addr_err_nxt_s;
    logic        pend_valid_nxt_s;
    logic [31:0] pend_tgt_nxt_s;
    prio_e       pend_prio_nxt_s;

    assign pc_plus4_s = pc_r + 32'd4;

    // Pick the highest-priority request and its raw target.
    always_comb begin
        sel_prio_s = PRIO_SEQ;
        sel_tgt_s  = pc_plus4_s;
        if (exc) begin
            sel_prio_s = PRIO_EXC;
            sel_tgt_s  = EXC_VEC;
        end else if (eret) begin
            sel_prio_s = PRIO_ERET;
            sel_tgt_s  = epc;
        end else if (jr) begin
            sel_prio_s = PRIO_JR;
            sel_tgt_s  = jr_target;
        end else if (jump) begin
            sel_prio_s = PRIO_JUMP;
            sel_tgt_s  = {pc_plus4_s[31:28], instr_index, 2'b00};
        end else if (br_taken) begin
            sel_prio_s = PRIO_BR;
            sel_tgt_s  = pc_plus4_s + br_off;
        end else begin
            sel_prio_s = PRIO_SEQ;
            sel_tgt_s  = pc_plus4_s;
        end
    end

    // Misaligned non-sequential targets divert to the exception vector; exc itself is exempt.
    always_comb begin
        misaligned_s = 1'b0;
        case (sel_prio_s)
            PRIO_BR, PRIO_JUMP, PRIO_JR, PRIO_ERET:
                misaligned_s = (sel_tgt_s[1:0] != 2'b00);
            PRIO_SEQ, PRIO_EXC:
                misaligned_s = 1'b0;
            default:
                misaligned_s = 1'b0;
        endcase
        if (misaligned_s) begin
            chk_tgt_s = EXC_VEC;
        end else begin
            chk_tgt_s = sel_tgt_s;
        end
    end

    // Next-state logic: capture into the pending latch while stalled, drain it first on release.
    always_comb begin
        pc_nxt_s         = pc_r;
        redirect_nxt_s   = 1'b0;
        addr_err_nxt_s   = 1'b0;
        pend_valid_nxt_s = pend_valid_r;
        pend_tgt_nxt_s   = pend_tgt_r;
        pend_prio_nxt_s  = pend_prio_r;
        if (stall) begin
            // Equal priority overwrites so the latest same-class request wins.
            if ((sel_prio_s != PRIO_SEQ) &&
                (!pend_valid_r || (sel_prio_s >= pend_prio_r))) begin
                pend_valid_nxt_s = 1'b1;
                pend_tgt_nxt_s   = chk_tgt_s;
                pend_prio_nxt_s  = sel_prio_s;
                addr_err_nxt_s   = misaligned_s;
            end else begin
                pend_valid_nxt_s = pend_valid_r;
            end
        end else if (pend_valid_r) begin
            if (exc) begin
                pc_nxt_s = EXC_VEC;
            end else begin
                pc_nxt_s = pend_tgt_r;
            end
            redirect_nxt_s   = 1'b1;
            pend_valid_nxt_s = 1'b0;
            pend_tgt_nxt_s   = 32'h0000_0000;
            pend_prio_nxt_s  = PRIO_SEQ;
        end else begin
            pc_nxt_s       = chk_tgt_s;
            redirect_nxt_s = (sel_prio_s != PRIO_SEQ);
            addr_err_nxt_s = misaligned_s;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r         <= RESET_PC;
            redirect_r   <= 1'b0;
            addr_err_r   <= 1'b0;
            pend_valid_r <= 1'b0;
            pend_tgt_r   <= 32'h0000_0000;
            pend_prio_r  <= PRIO_SEQ;
        end else begin
            pc_r         <= pc_nxt_s;
            redirect_r   <= redirect_nxt_s;
            addr_err_r   <= addr_err_nxt_s;
            pend_valid_r <= pend_valid_nxt_s;
            pend_tgt_r   <= pend_tgt_nxt_s;
            pend_prio_r  <= pend_prio_nxt_s;
        end
    end

    assign pc       = pc_r;
    assign pc_plus4 = pc_plus4_s;
    assign redirect = redirect_r;
    assign addr_err = addr_err_r;

endmodule

// File: tb/tb_pc_next_unit.sv
// Self-checking bench for pc_next_unit: directed test-plan scenarios followed by
// randomized traffic compared against a request-table reference model.
module tb_pc_next_unit;

    localparam logic [31:0] RESET_PC = 32'h0040_0000;
    localparam logic [31:0] EXC_VEC  = 32'h0040_0004;

    logic        clk = 1'b0;
    logic        rst, stall, br_taken, jump, jr, exc, eret;
    logic [31:0] br_off, jr_target, epc;
    logic [25:0] instr_index;
    logic [31:0] pc, pc_plus4;
    logic        redirect, addr_err;

    int total = 0;
    int bad   = 0;

    logic [31:0] m_pc;
    logic        m_redirect, m_addr_err, m_pend_valid;
    logic [31:0] m_pend_tgt;
    int          m_pend_rank;

    always #5 clk = ~clk;

    pc_next_unit #(.RESET_PC(RESET_PC), .EXC_VEC(EXC_VEC)) dut (
        .clk(clk), .rst(rst), .stall(stall), .br_taken(br_taken), .br_off(br_off),
        .jump(jump), .instr_index(instr_index), .jr(jr), .jr_target(jr_target),
        .exc(exc), .eret(eret), .epc(epc), .pc(pc), .pc_plus4(pc_plus4),
        .redirect(redirect), .addr_err(addr_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: list every request with its rank and target, take the top one.
    function automatic void model_edge();
        logic [31:0] seq;
        logic [31:0] tg[6];
        logic        rq[6];
        int          best;
        logic [31:0] tgt;
        logic        mis;
        seq = m_pc + 32'd4;
        rq[0] = 1'b1;     tg[0] = seq;
        rq[1] = br_taken; tg[1] = seq + br_off;
        rq[2] = jump;     tg[2] = {seq[31:28], instr_index, 2'b00};
        rq[3] = jr;       tg[3] = jr_target;
        rq[4] = eret;     tg[4] = epc;
        rq[5] = exc;      tg[5] = EXC_VEC;
        best = 0;
        for (int i = 0; i < 6; i++) if (rq[i]) best = i;
        tgt = tg[best];
        mis = (best >= 1) && (best <= 4) && (tgt % 4 != 0);
        if (mis) tgt = EXC_VEC;
        m_redirect = 1'b0;
        m_addr_err = 1'b0;
        if (rst) begin
            m_pc = RESET_PC; m_pend_valid = 1'b0; m_pend_tgt = 32'd0; m_pend_rank = 0;
        end else if (stall) begin
            if (best > 0 && (!m_pend_valid || best >= m_pend_rank)) begin
                m_pend_valid = 1'b1; m_pend_tgt = tgt; m_pend_rank = best;
                m_addr_err = mis;
            end
        end else if (m_pend_valid) begin
            m_pc = exc ? EXC_VEC : m_pend_tgt;
            m_redirect = 1'b1;
            m_pend_valid = 1'b0;
        end else begin
            m_pc = tgt;
            m_redirect = (best > 0);
            m_addr_err = mis;
        end
    endfunction

    task automatic idle_inputs();
        rst = 1'b0; stall = 1'b0; br_taken = 1'b0; jump = 1'b0; jr = 1'b0;
        exc = 1'b0; eret = 1'b0; br_off = 32'd0; jr_target = 32'd0; epc = 32'd0;
        instr_index = 26'd0;
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
        check("pc", pc, m_pc);
        check("pc_plus4", pc_plus4, m_pc + 32'd4);
        check("redirect", {31'd0, redirect}, {31'd0, m_redirect});
        check("addr_err", {31'd0, addr_err}, {31'd0, m_addr_err});
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        cycle();
        check("tp_reset_pc", pc, 32'h0040_0000);
        rst = 1'b0;
        cycle(); check("tp_seq1", pc, 32'h0040_0004);
        cycle(); check("tp_seq2", pc, 32'h0040_0008);
        cycle(); check("tp_seq3", pc, 32'h0040_000C);
        cycle(); check("tp_at410", pc, 32'h0040_0010);
        // branch backwards
        br_taken = 1'b1; br_off = 32'hFFFF_FFF8;
        cycle(); check("tp_branch", pc, 32'h0040_000C);
        check("tp_branch_redir", {31'd0, redirect}, 32'd1);
        idle_inputs();
        cycle(); check("tp_redir_drop", {31'd0, redirect}, 32'd0);
        repeat (4) cycle();
        check("tp_at420", pc, 32'h0040_0020);
        jump = 1'b1; br_taken = 1'b1; br_off = 32'h0000_0040; instr_index = 26'h010_0040;
        cycle(); check("tp_jump_wins", pc, 32'h0040_0100);
        idle_inputs();
        // jr during a three-cycle stall
        stall = 1'b1; jr = 1'b1; jr_target = 32'h0040_0200;
        cycle(); check("tp_stall_hold", pc, 32'h0040_0100);
        jr = 1'b0;
        cycle(); cycle();
        check("tp_stall_noredir", {31'd0, redirect}, 32'd0);
        stall = 1'b0;
        cycle(); check("tp_pend_apply", pc, 32'h0040_0200);
        check("tp_pend_redir", {31'd0, redirect}, 32'd1);
        cycle(); check("tp_pend_once", {31'd0, redirect}, 32'd0);
        // misaligned jr
        jr = 1'b1; jr_target = 32'h0040_0202;
        cycle(); check("tp_misalign_pc", pc, EXC_VEC);
        check("tp_misalign_err", {31'd0, addr_err}, 32'd1);
        idle_inputs();
        cycle(); check("tp_err_drop", {31'd0, addr_err}, 32'd0);
        // reset discards pending redirect
        stall = 1'b1; jr = 1'b1; jr_target = 32'h0040_0800;
        cycle();
        jr = 1'b0; rst = 1'b1;
        cycle(); check("tp_rst_stall", pc, 32'h0040_0000);
        idle_inputs();
        cycle(); check("tp_pend_dropped", pc, 32'h0040_0004);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            rst      = ($urandom_range(0, 199) == 0);
            stall    = ($urandom_range(0, 3) == 0);
            exc      = ($urandom_range(0, 24) == 0);
            eret     = ($urandom_range(0, 14) == 0);
            jr       = ($urandom_range(0, 9) == 0);
            jump     = ($urandom_range(0, 9) == 0);
            br_taken = ($urandom_range(0, 5) == 0);
            br_off   = $urandom_range(0, 1) == 1 ? 32'hFFFF_FF00 | $urandom_range(0, 255)
                                                 : 32'(int'($urandom_range(0, 1023)));
            if ($urandom_range(0, 3) != 0) br_off[1:0] = 2'b00;
            jr_target = 32'h0040_0000 | 32'($urandom_range(0, 4095));
            if ($urandom_range(0, 3) != 0) jr_target[1:0] = 2'b00;
            epc = $urandom;
            if ($urandom_range(0, 3) != 0) epc[1:0] = 2'b00;
            instr_index = 26'($urandom);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
